// File: rtl/pc_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding, event codes, opcode constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pc_pkg;

   // Sequencer states. TRAP only exists when misaligned-redirect trapping is built in.
   typedef enum logic [2:0] {
      ST_RUN   = 3'd0,
      ST_STALL = 3'd1,
      ST_FLUSH = 3'd2,
      ST_HALT  = 3'd3
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      ,
      ST_TRAP  = 3'd4
`endif
   } pc_state_e;

   // Resolved event codes from pc_event_prio, highest priority first.
   localparam logic [1:0] EV_NONE     = 2'd0;
   localparam logic [1:0] EV_REDIRECT = 2'd1;
   localparam logic [1:0] EV_HALT     = 2'd2;
   localparam logic [1:0] EV_STALL    = 2'd3;

   localparam logic [6:0]  HALT_OPCODE = 7'b1111111;
   localparam int unsigned PC_INCR     = 4;

   // A real (non-bubble) instruction carrying the halt opcode.
   function automatic logic is_halt_op(input logic [6:0] op, input logic op_valid);
      return op_valid && (op == HALT_OPCODE);
   endfunction

endpackage

// File: rtl/pc_event_prio.sv
// Purpose: combinational priority resolve of redirect / halt / stall into one event code.
// Ports: redirect, stall, opcode, opcode_valid, in_run (state is RUN) -> evt (EV_* code).
// Latency: 0 cycles (pure combinational). Backpressure: none; stall is just one of the events.
module pc_event_prio
   import pc_pkg::*;
(
   input  logic       redirect,
   input  logic       stall,
   input  logic [6:0] opcode,
   input  logic       opcode_valid,
   input  logic       in_run,
   output logic [1:0] evt
);

   logic halt_det;

   // A halt is only honoured from RUN and never while stalled: a stalled
   // opcode will be re-presented by decode once the stall drops.
   assign halt_det = is_halt_op(opcode, opcode_valid) && in_run && !stall;

   always_comb begin
      evt = EV_NONE;
      if (redirect) begin
         evt = EV_REDIRECT;
      end else if (halt_det) begin
         evt = EV_HALT;
      end else if (stall) begin
         evt = EV_STALL;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Purpose: fetch program-counter sequencer with RUN/STALL/FLUSH/HALT states (TRAP optional).
// Ports: clk, pc_rst_n (sync, active-low), stall, redirect, redirect_target, opcode,
//        opcode_valid -> pc, pc_valid, flush_if_id, halted (all registered).
// Latency: 1 cycle from any event to registered outputs; redirect target fetched valid 2 cycles later.
// Backpressure: stall holds the PC and drops pc_valid; HALT is left only by reset.
// Optional feature macro: PC_SEQ_MISALIGN_TRAP_EN (misaligned redirect enters TRAP at TRAP_VECTOR).
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int                  PC_WIDTH     = 32,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100
)
(
   input  logic                clk,
   input  logic                pc_rst_n,
   input  logic                stall,
   input  logic                redirect,
   input  logic [PC_WIDTH-1:0] redirect_target,
   input  logic [6:0]          opcode,
   input  logic                opcode_valid,
   output logic [PC_WIDTH-1:0] pc,
   output logic                pc_valid,
   output logic                flush_if_id,
   output logic                halted
);

   pc_state_e           state;
   pc_state_e           state_nxt;
   logic [PC_WIDTH-1:0] pc_nxt;
   logic                valid_nxt;
   logic                flush_nxt;
   logic                halted_nxt;
   logic [1:0]          evt;
   logic [PC_WIDTH-1:0] tgt_aligned;
   logic                in_flush;

   // Fetch addresses are always word aligned; the low target bits never reach pc.
   assign tgt_aligned = {redirect_target[PC_WIDTH-1:2], 2'b00};

`ifdef PC_SEQ_MISALIGN_TRAP_EN
   logic misalign;
   assign misalign = |redirect_target[1:0];
   assign in_flush = (state == ST_FLUSH) || (state == ST_TRAP);
`else
   // Low target bits and the trap vector only matter when trapping is built in.
   logic unused_ok;
   assign unused_ok = ^{redirect_target[1:0], TRAP_VECTOR};
   assign in_flush  = (state == ST_FLUSH);
`endif

   pc_event_prio u_prio (
      .redirect     (redirect),
      .stall        (stall),
      .opcode       (opcode),
      .opcode_valid (opcode_valid),
      .in_run       (state == ST_RUN),
      .evt          (evt)
   );

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      valid_nxt  = pc_valid;
      flush_nxt  = 1'b0;       // one-cycle squash; only set on FLUSH/TRAP entry
      halted_nxt = halted;

      if (state == ST_HALT) begin
         // Terminal until reset: redirect and stall have no effect.
         valid_nxt  = 1'b0;
         halted_nxt = 1'b1;
      end else if (evt == EV_REDIRECT) begin
         flush_nxt = 1'b1;
         valid_nxt = 1'b0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
         if (misalign) begin
            state_nxt = ST_TRAP;
            pc_nxt    = TRAP_VECTOR;
         end else begin
            state_nxt = ST_FLUSH;
            pc_nxt    = tgt_aligned;
         end
`else
         state_nxt = ST_FLUSH;
         pc_nxt    = tgt_aligned;
`endif
      end else if (in_flush) begin
         // Squash cycle done: fetch the new target; increments resume next cycle.
         state_nxt = ST_RUN;
         valid_nxt = 1'b1;
      end else if (evt == EV_HALT) begin
         state_nxt  = ST_HALT;
         valid_nxt  = 1'b0;
         halted_nxt = 1'b1;
      end else if (evt == EV_STALL) begin
         state_nxt = ST_STALL;
         valid_nxt = 1'b0;
      end else if (state == ST_STALL) begin
         // Re-fetch the held PC once the hazard clears.
         state_nxt = ST_RUN;
         valid_nxt = 1'b1;
      end else begin
         state_nxt = ST_RUN;
         pc_nxt    = pc + PC_WIDTH'(PC_INCR);
         valid_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!pc_rst_n) begin
         state       <= ST_RUN;
         pc          <= RESET_VECTOR;
         pc_valid    <= 1'b1;
         flush_if_id <= 1'b0;
         halted      <= 1'b0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         pc_valid    <= valid_nxt;
         flush_if_id <= flush_nxt;
         halted      <= halted_nxt;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose: directed scoreboard bench for pc_sequencer; driver queues per-cycle expectations.
// Latency: expectation for each clock edge is checked on the following falling edge.
// Backpressure: n/a.
module tb_pc_sequencer;

   logic        clk;
   logic        pc_rst_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_target;
   logic [6:0]  opcode;
   logic        opcode_valid;
   logic [31:0] pc;
   logic        pc_valid;
   logic        flush_if_id;
   logic        halted;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic        vld;
      logic        flush;
      logic        halted;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks;
   int   n_fail;

   pc_sequencer dut (
      .clk             (clk),
      .pc_rst_n        (pc_rst_n),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .opcode          (opcode),
      .opcode_valid    (opcode_valid),
      .pc              (pc),
      .pc_valid        (pc_valid),
      .flush_if_id     (flush_if_id),
      .halted          (halted)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle of inputs and queue the outputs expected after the edge.
   task automatic step(input string nm, input logic rn, input logic st, input logic rd,
                       input logic [31:0] tg, input logic [6:0] op, input logic ov,
                       input logic [31:0] epc, input logic ev, input logic ef, input logic eh);
      exp_t e;
      pc_rst_n        = rn;
      stall           = st;
      redirect        = rd;
      redirect_target = tg;
      opcode          = op;
      opcode_valid    = ov;
      @(posedge clk);
      e.name = nm; e.pc = epc; e.vld = ev; e.flush = ef; e.halted = eh;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic free(input string nm, input logic [31:0] epc);
      step(nm, 1'b1, 1'b0, 1'b0, 32'h0, 7'h00, 1'b0, epc, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic redir(input string nm, input logic [31:0] tg);
      step(nm, 1'b1, 1'b0, 1'b1, tg, 7'h00, 1'b0, tg, 1'b0, 1'b1, 1'b0);
   endtask

   // Monitor: outputs are registered, so every cycle presents a result.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({pc, pc_valid, flush_if_id, halted} !== {e.pc, e.vld, e.flush, e.halted}) begin
               n_fail++;
               $display("FAIL %s: got pc=%h vld=%b flush=%b halted=%b, want pc=%h vld=%b flush=%b halted=%b",
                        e.name, pc, pc_valid, flush_if_id, halted, e.pc, e.vld, e.flush, e.halted);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;

      // Reset and free-running increment
      step("reset", 1'b0, 1'b0, 1'b0, 32'h0, 7'h00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      free("inc_4", 32'h4);
      free("inc_8", 32'h8);
      free("inc_c", 32'hC);
      free("inc_10", 32'h10);

      // Redirect from RUN
      redir("redir_flush", 32'h200);
      free("redir_fetch", 32'h200);
      free("redir_inc", 32'h204);

      // Walk to 0x20, then a three-cycle stall
      redir("to_1c_flush", 32'h1C);
      free("to_1c_fetch", 32'h1C);
      free("to_20", 32'h20);
      step("stall_1", 1'b1, 1'b1, 1'b0, 32'h0, 7'h00, 1'b0, 32'h20, 1'b0, 1'b0, 1'b0);
      step("stall_2", 1'b1, 1'b1, 1'b0, 32'h0, 7'h00, 1'b0, 32'h20, 1'b0, 1'b0, 1'b0);
      step("stall_3", 1'b1, 1'b1, 1'b0, 32'h0, 7'h00, 1'b0, 32'h20, 1'b0, 1'b0, 1'b0);
      free("stall_exit", 32'h20);
      free("stall_inc", 32'h24);

      // Redirect while in FLUSH restarts it with the new target
      redir("flush_a", 32'h300);
      redir("flush_b", 32'h400);
      free("flush_b_fetch", 32'h400);
      free("flush_b_inc", 32'h404);

      // Misaligned redirect target
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      step("mis_trap", 1'b1, 1'b0, 1'b1, 32'h202, 7'h00, 1'b0, 32'h100, 1'b0, 1'b1, 1'b0);
      free("trap_fetch", 32'h100);
      free("trap_inc", 32'h104);
`else
      step("mis_mask", 1'b1, 1'b0, 1'b1, 32'h202, 7'h00, 1'b0, 32'h200, 1'b0, 1'b1, 1'b0);
      free("mis_fetch", 32'h200);
      free("mis_inc", 32'h204);
`endif

      // Redirect accepted from STALL
      redir("pre_stall_flush", 32'h480);
      free("pre_stall_fetch", 32'h480);
      step("stall_hold", 1'b1, 1'b1, 1'b0, 32'h0, 7'h00, 1'b0, 32'h480, 1'b0, 1'b0, 1'b0);
      step("stall_redir", 1'b1, 1'b1, 1'b1, 32'h500, 7'h00, 1'b0, 32'h500, 1'b0, 1'b1, 1'b0);
      free("stall_redir_fetch", 32'h500);

      // Halt opcode together with redirect: redirect wins
      step("halt_vs_redir", 1'b1, 1'b0, 1'b1, 32'h600, 7'h7F, 1'b1, 32'h600, 1'b0, 1'b1, 1'b0);
      free("halt_vs_redir_fetch", 32'h600);
      // Halt opcode under stall is ignored, also on the stall-release cycle
      step("halt_in_stall", 1'b1, 1'b1, 1'b0, 32'h0, 7'h7F, 1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
      step("halt_stall_exit", 1'b1, 1'b0, 1'b0, 32'h0, 7'h7F, 1'b1, 32'h600, 1'b1, 1'b0, 1'b0);
      // Halt opcode on a bubble is ignored
      step("halt_bubble", 1'b1, 1'b0, 1'b0, 32'h0, 7'h7F, 1'b0, 32'h604, 1'b1, 1'b0, 1'b0);
      // Real halt
      step("halt_enter", 1'b1, 1'b0, 1'b0, 32'h0, 7'h7F, 1'b1, 32'h604, 1'b0, 1'b0, 1'b1);
      step("halt_redir_ign", 1'b1, 1'b0, 1'b1, 32'h700, 7'h00, 1'b0, 32'h604, 1'b0, 1'b0, 1'b1);
      step("halt_stall_ign", 1'b1, 1'b1, 1'b0, 32'h0, 7'h00, 1'b0, 32'h604, 1'b0, 1'b0, 1'b1);
      free_halted();
      step("halt_reset", 1'b0, 1'b0, 1'b0, 32'h0, 7'h00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      free("post_halt_inc", 32'h4);

      // Wrap at the top of the address space
      redir("wrap_flush", 32'hFFFF_FFFC);
      free("wrap_fetch", 32'hFFFF_FFFC);
      free("wrap_zero", 32'h0);

      // Reset mid-FLUSH discards the pending target
      redir("pre_rst_flush", 32'h800);
      step("rst_in_flush", 1'b0, 1'b0, 1'b1, 32'h900, 7'h00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      free("post_rst_4", 32'h4);
      free("post_rst_8", 32'h8);

      @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Idle cycle while halted: outputs stay frozen.
   task automatic free_halted();
      step("halt_idle", 1'b1, 1'b0, 1'b0, 32'h0, 7'h00, 1'b0, 32'h604, 1'b0, 1'b0, 1'b1);
   endtask

endmodule
